datapath_param: RTL and testbench
=================================

DATAPATH_PARAM -- requirements
Module: datapath_param

Interface
REQ-001 SHALL have parameter W, default 4: data width in bits, W >= 2.
REQ-002 SHALL have parameter NREG, default 8: register count, power of two >= 2; AW = clog2(NREG).
REQ-003 SHALL derive CTRL_W = 3*AW + 7 (16 at defaults); control layout MSB to LSB {srcA[AW], srcB[AW], dest[AW], op[4], mode[3]}.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port control, input, CTRL_W bits: control word.
REQ-007 SHALL have port ctrl_valid, input, 1 bit: control and datain are valid this cycle.
REQ-008 SHALL have port ctrl_ready, output, 1 bit: block accepts a control word this cycle.
REQ-009 SHALL have port datain, input, W bits: external operand.
REQ-010 SHALL have port dataout, output, W bits: registered result of the last completed operation.
REQ-011 SHALL have port banderas, output, 4 bits {Z,N,C,V}: registered flags.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking an operation completed.

Function
REQ-013 SHALL implement states IDLE, EXEC and MUL; ctrl_ready = 1 only in IDLE.
REQ-014 SHALL accept a control word on an edge where ctrl_valid && ctrl_ready, latching the control fields, A = reg[srcA] and B (datain if mode[0], else reg[srcB]).
REQ-015 SHALL go from IDLE to MUL when op = 10, and to EXEC for every other op.
REQ-016 SHALL, in EXEC, compute the result and apply writeback on the next edge, then return to IDLE; accept at edge k gives writeback at edge k+1 and done = 1 in the cycle after edge k+1.
REQ-017 SHALL, in MUL, run a shift-add multiply for exactly W cycles, apply writeback on the W-th MUL edge, then return to IDLE.
REQ-018 SHALL define writeback as: reg[dest] <= result if mode[1]; dataout <= result always; banderas <= flags if mode[2]; done pulsed.
REQ-019 SHALL hold reg[0] at zero permanently; writes to reg[0] are discarded, while dataout and flags still update.
REQ-020 SHALL implement ops 0 pass B, 1 A+B, 2 A-B, 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 A<<1, 8 A>>1 (logical), 9 rotate-left A, 10 A*B (low W bits), 11 A+1, 12 A-1, 13 compare (A-B, reg write suppressed regardless of mode[1]); ops 14-15 are NOP with no writeback but still pulse done.
REQ-021 SHALL compute Z = (result == 0) and N = result[W-1] for all ops.
REQ-022 SHALL set C as: add/inc = carry-out; sub/dec/cmp = borrow (A < subtrahend, unsigned); shl = A[W-1]; shr = A[0]; mul = 1 if high W bits of product are nonzero; all others 0.
REQ-023 SHALL set V = two's-complement overflow for add/sub/inc/dec/cmp, and 0 otherwise.
REQ-024 SHALL ignore ctrl_valid outside IDLE; control and datain are not sampled then.
REQ-025 SHALL make source operands see every earlier writeback (writeback always completes before the next accept), so no hazard exists.

Reset
REQ-026 SHALL, on rst = 1 at an edge: all registers and dataout to 0, banderas to 4'b0000, done to 0, state to IDLE (ctrl_ready = 1 next cycle).
REQ-027 SHALL, when rst is asserted during EXEC or MUL, abort the operation with no writeback and no done pulse; rst has priority over acceptance.

Verification (W=4, NREG=8)
REQ-028 SHALL cover the load/add sequence: load r1 = 4'b0011 and r2 = 4'b1010 (op 0, mode 3'b011 with datain), then add r3 = r1+r2 with mode 3'b110 -> r3 = 4'b1101, flags Z0 N1 C0 V0, done exactly 1 cycle after writeback edge.
REQ-029 SHALL cover add overflow: r2+r2 -> dataout = 4'b0100, flags C1 V1 N0 Z0.
REQ-030 SHALL cover multiply: r1 = 3, r4 = 5, mul -> 4'b1111, C0; r4*r4 -> 4'b1001, C1; ctrl_ready low exactly W+1 cycles after accept.
REQ-031 SHALL cover r0 and cmp: write datain 4'b0111 to r0 -> reg[0] stays 0, dataout = 4'b0111; cmp r1,r1 -> Z1, dest unchanged.
REQ-032 SHALL cover reset mid-multiply: rst on the 2nd MUL cycle -> no done, all registers 0, ctrl_ready = 1 the next cycle.
REQ-033 SHALL cover the handshake: ctrl_valid held high continuously with varying control -> only words present on IDLE cycles executed, back-to-back single-cycle ops every 2 cycles.

Source files
------------

// File: rtl/datapath_param.sv
// Parameterised register-file datapath: one ALU operation per accepted control word,
// with a W-cycle shift-add multiplier and registered result/flag outputs.
module datapath_param #(
    parameter  int W      = 4,
    parameter  int NREG   = 8,
    localparam int AW     = $clog2(NREG),
    localparam int CTRL_W = 3*AW + 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] control,
    input  logic              ctrl_valid,
    output logic              ctrl_ready,
    input  logic [W-1:0]      datain,
    output logic [W-1:0]      dataout,
    output logic [3:0]        banderas,
    output logic              done
);

    localparam int CW = $clog2(W) + 1;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_INC  = 4'd11;
    localparam logic [3:0] OP_DEC  = 4'd12;
    localparam logic [3:0] OP_CMP  = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_done;
    logic [W-1:0]    r_dout;
    logic [3:0]      r_flags;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [AW-1:0]   r_dest;
    logic [3:0]      r_op;
    logic [2:0]      r_mode;

    logic [2*W-1:0]  r_acc;
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_mplier;
    logic [CW-1:0]   r_cnt;

    logic [AW-1:0]   w_src_a;
    logic [AW-1:0]   w_src_b;
    logic [AW-1:0]   w_dest;
    logic [3:0]      w_op;
    logic [2:0]      w_mode;
    logic [W-1:0]    w_regs [NREG];
    logic [W-1:0]    w_opa;
    logic [W-1:0]    w_opb;

    logic [2*W-1:0]  w_mul_add;
    logic [2*W-1:0]  w_acc_next;
    logic            w_mul_last;

    logic [W:0]      w_sum;
    logic [W-1:0]    w_res;
    logic            w_c;
    logic            w_v;
    logic [3:0]      w_flags;
    logic            w_is_nop;
    logic            w_wb;
    logic            w_reg_we;

    // Control word layout, MSB first: srcA, srcB, dest, op, mode.
    assign w_src_a = control[CTRL_W-1 -: AW];
    assign w_src_b = control[CTRL_W-AW-1 -: AW];
    assign w_dest  = control[AW+6 -: AW];
    assign w_op    = control[6:3];
    assign w_mode  = control[2:0];

    assign w_opa = w_regs[w_src_a];
    assign w_opb = w_mode[0] ? datain : w_regs[w_src_b];

    assign w_mul_add  = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_mul_add;
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(W-1));

    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_op)
            OP_PASS: w_res = r_b;
            OP_ADD: begin
                w_sum = {1'b0, r_a} + {1'b0, r_b};
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
                w_v   = (r_a[W-1] == r_b[W-1]) && (w_res[W-1] != r_a[W-1]);
            end
            OP_SUB, OP_CMP: begin
                // Bit W of the widened difference is the unsigned borrow.
                w_sum = {1'b0, r_a} - {1'b0, r_b};
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
                w_v   = (r_a[W-1] != r_b[W-1]) && (w_res[W-1] != r_a[W-1]);
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_NOT: w_res = ~r_a;
            OP_SHL: begin
                w_res = {r_a[W-2:0], 1'b0};
                w_c   = r_a[W-1];
            end
            OP_SHR: begin
                w_res = {1'b0, r_a[W-1:1]};
                w_c   = r_a[0];
            end
            OP_ROL: w_res = {r_a[W-2:0], r_a[W-1]};
            OP_MUL: begin
                w_res = w_acc_next[W-1:0];
                w_c   = |w_acc_next[2*W-1:W];
            end
            OP_INC: begin
                w_sum = {1'b0, r_a} + (W+1)'(1);
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
                w_v   = !r_a[W-1] && w_res[W-1];
            end
            OP_DEC: begin
                w_sum = {1'b0, r_a} - (W+1)'(1);
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
                w_v   = r_a[W-1] && !w_res[W-1];
            end
            default: ;
        endcase
    end

    assign w_flags  = {(w_res == '0), w_res[W-1], w_c, w_v};
    assign w_is_nop = (r_op[3:1] == 3'b111);
    assign w_wb     = (r_state == S_EXEC) || w_mul_last;
    assign w_reg_we = w_wb && !w_is_nop && r_mode[1] && (r_op != OP_CMP);

    // Register file; entry 0 is a constant zero so writes to it simply vanish.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_file
                logic [W-1:0] r_q;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_q <= '0;
                    end else if (w_reg_we && (r_dest == AW'(gi))) begin
                        r_q <= w_res;
                    end
                end
                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_dout   <= '0;
            r_flags  <= 4'b0000;
            r_a      <= '0;
            r_b      <= '0;
            r_dest   <= '0;
            r_op     <= '0;
            r_mode   <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctrl_valid) begin
                        r_a     <= w_opa;
                        r_b     <= w_opb;
                        r_dest  <= w_dest;
                        r_op    <= w_op;
                        r_mode  <= w_mode;
                        r_ready <= 1'b0;
                        if (w_op == OP_MUL) begin
                            r_state  <= S_MUL;
                            r_acc    <= '0;
                            r_mcand  <= {{W{1'b0}}, w_opa};
                            r_mplier <= w_opb;
                            r_cnt    <= '0;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_mul_last) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase

            // NOPs still signal completion but leave result and flags untouched.
            if (w_wb) begin
                r_done <= 1'b1;
                if (!w_is_nop) begin
                    r_dout <= w_res;
                    if (r_mode[2]) begin
                        r_flags <= w_flags;
                    end
                end
            end
        end
    end

    assign ctrl_ready = r_ready;
    assign dataout    = r_dout;
    assign banderas   = r_flags;
    assign done       = r_done;

endmodule

// File: tb/tb_datapath_param.sv
// Bench for datapath_param: directed scenarios, continuous-valid handshake and random
// operations, all checked against an arithmetic reference model.
module tb_datapath_param;

    localparam int W      = 4;
    localparam int NREG   = 8;
    localparam int AW     = $clog2(NREG);
    localparam int CTRL_W = 3*AW + 7;
    localparam int HALF   = 1 << (W-1);
    localparam int FULL   = 1 << W;

    logic              clk;
    logic              rst;
    logic [CTRL_W-1:0] control;
    logic              ctrl_valid;
    logic              ctrl_ready;
    logic [W-1:0]      datain;
    logic [W-1:0]      dataout;
    logic [3:0]        banderas;
    logic              done;

    datapath_param #(.W(W), .NREG(NREG)) dut (
        .clk        (clk),
        .rst        (rst),
        .control    (control),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .datain     (datain),
        .dataout    (dataout),
        .banderas   (banderas),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int m_regs [NREG];
    int m_dout;
    int m_flags;
    int m_lat;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= HALF) ? x - FULL : x;
    endfunction

    function automatic int ovf(input int s);
        return ((s > HALF - 1) || (s < -HALF)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 0;
        m_dout  = 0;
        m_flags = 0;
    endtask

    task automatic model_apply(input int sa, input int sb, input int d,
                               input int op, input int mode, input int din);
        int a, b, r, c, v, t;
        a = m_regs[sa];
        b = (mode & 1) ? din : m_regs[sb];
        r = 0; c = 0; v = 0;
        case (op)
            0:  r = b;
            1:  begin t = a + b; r = t % FULL; c = (t >= FULL); v = ovf(sgn(a) + sgn(b)); end
            2, 13: begin r = (a - b) & (FULL - 1); c = (a < b); v = ovf(sgn(a) - sgn(b)); end
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = (FULL - 1) - a;
            7:  begin r = (a * 2) % FULL; c = (a >= HALF); end
            8:  begin r = a / 2; c = a % 2; end
            9:  r = ((a * 2) % FULL) + (a / HALF);
            10: begin t = a * b; r = t % FULL; c = (t / FULL) != 0; end
            11: begin t = a + 1; r = t % FULL; c = (t >= FULL); v = ovf(sgn(a) + 1); end
            12: begin r = (a - 1) & (FULL - 1); c = (a < 1); v = ovf(sgn(a) - 1); end
            default: ;
        endcase
        m_lat = (op == 10) ? W : 1;
        if (op < 14) begin
            m_dout = r;
            if (mode & 4)
                m_flags = ((r == 0) ? 8 : 0) | ((r >= HALF) ? 4 : 0) | (c ? 2 : 0) | (v ? 1 : 0);
            if ((mode & 2) && op != 13 && d != 0)
                m_regs[d] = r;
        end
    endtask

    function automatic logic [CTRL_W-1:0] pack(input int sa, input int sb, input int d,
                                               input int op, input int mode);
        return CTRL_W'((sa << (2*AW+7)) | (sb << (AW+7)) | (d << 7) | (op << 3) | mode);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic do_op(input int sa, input int sb, input int d,
                         input int op, input int mode, input int din);
        int  cyc;
        bit  seen;
        check("idle_ready", ctrl_ready, 1);
        control    = pack(sa, sb, d, op, mode);
        datain     = W'(din);
        ctrl_valid = 1'b1;
        model_apply(sa, sb, d, op, mode, din);
        @(posedge clk);
        #1;
        ctrl_valid = 1'b0;
        control    = CTRL_W'($urandom);
        datain     = W'($urandom);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else check("busy_ready", ctrl_ready, 0);
        end
        check("done_latency", cyc, m_lat + 1);
        check("dataout", dataout, m_dout);
        check("flags", banderas, m_flags);
        check("ready_after", ctrl_ready, 1);
        $display("[TB] op=%0d a=r%0d b=%0d dest=r%0d mode=%03b din=%0h -> dout=%0h flags=%04b",
                 op, sa, sb, d, mode, din, dataout, banderas);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  exp_rdy, exp_done;
        int  sa, sb, d, op, mode, din;

        rst        = 1'b1;
        ctrl_valid = 1'b0;
        control    = '0;
        datain     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ctrl_ready, 1);
        check("rst_done", done, 0);
        check("rst_dataout", dataout, 0);
        check("rst_flags", banderas, 0);

        // Load / add
        do_op(0, 0, 1, 0, 3'b011, 4'b0011);
        do_op(0, 0, 2, 0, 3'b011, 4'b1010);
        do_op(1, 2, 3, 1, 3'b110, 0);
        check("add_result", dataout, 4'b1101);
        check("add_flags", banderas, 4'b0100);

        // Add overflow
        do_op(2, 2, 5, 1, 3'b110, 0);
        check("ovf_result", dataout, 4'b0100);
        check("ovf_flags", banderas, 4'b0011);

        // Multiply
        do_op(0, 0, 4, 0, 3'b011, 5);
        do_op(1, 4, 6, 10, 3'b110, 0);
        check("mul_result", dataout, 4'b1111);
        check("mul_carry", banderas[1], 0);
        do_op(4, 4, 7, 10, 3'b110, 0);
        check("mul2_result", dataout, 4'b1001);
        check("mul2_carry", banderas[1], 1);

        // r0 stays zero; compare leaves dest untouched
        do_op(0, 0, 0, 0, 3'b011, 4'b0111);
        check("r0_dataout", dataout, 4'b0111);
        do_op(0, 0, 0, 0, 3'b000, 0);
        check("r0_read", dataout, 0);
        do_op(1, 1, 3, 13, 3'b110, 0);
        check("cmp_flags", banderas, 4'b1000);
        do_op(0, 3, 0, 0, 3'b000, 0);
        check("cmp_dest", dataout, 4'b1101);

        // Continuous valid: only words offered while idle execute, one every 2 cycles
        exp_rdy  = 1;
        exp_done = 1;
        for (int i = 0; i < 40; i++) begin
            check("hs_ready", ctrl_ready, exp_rdy);
            check("hs_done", done, exp_done);
            if (exp_done) begin
                check("hs_dataout", dataout, m_dout);
                check("hs_flags", banderas, m_flags);
            end
            sa   = $urandom_range(0, NREG-1);
            sb   = $urandom_range(0, NREG-1);
            d    = $urandom_range(0, NREG-1);
            op   = $urandom_range(0, 15);
            if (op == 10) op = 11;
            mode = $urandom_range(0, 7);
            din  = $urandom_range(0, FULL-1);
            control    = pack(sa, sb, d, op, mode);
            datain     = W'(din);
            ctrl_valid = 1'b1;
            if (exp_rdy) begin
                model_apply(sa, sb, d, op, mode, din);
                $display("[TB] hs accept op=%0d a=r%0d b=%0d dest=r%0d mode=%03b din=%0h",
                         op, sa, sb, d, mode, din);
                exp_rdy  = 0;
                exp_done = 0;
            end else begin
                exp_rdy  = 1;
                exp_done = 1;
            end
            @(negedge clk);
        end
        ctrl_valid = 1'b0;
        check("hs_ready_end", ctrl_ready, exp_rdy);
        check("hs_done_end", done, exp_done);
        if (exp_done) check("hs_dataout_end", dataout, m_dout);
        repeat (2) @(negedge clk);

        // Reset during the second multiply cycle aborts the operation
        check("rmul_idle", ctrl_ready, 1);
        control    = pack(4, 4, 6, 10, 3'b110);
        ctrl_valid = 1'b1;
        @(posedge clk);
        #1 ctrl_valid = 1'b0;
        @(negedge clk);
        check("rmul_cycle1_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        model_reset();
        check("rmul_ready", ctrl_ready, 1);
        check("rmul_done", done, 0);
        check("rmul_dataout", dataout, 0);
        check("rmul_flags", banderas, 0);
        repeat (W) begin
            @(negedge clk);
            check("rmul_no_done", done, 0);
        end
        for (int i = 0; i < NREG; i++) do_op(0, i, 0, 0, 3'b000, 0);

        // Randomised operations
        for (int i = 0; i < 150; i++) begin
            do_op($urandom_range(0, NREG-1), $urandom_range(0, NREG-1),
                  $urandom_range(0, NREG-1), $urandom_range(0, 15),
                  $urandom_range(0, 7), $urandom_range(0, FULL-1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
